udp_port_seq_match: RTL and testbench

- Parametrised, run-time-configurable UDP destination-port matcher for the Rx side of the Ethernet pipeline.
- Generalises the fixed 8-entry port table to n_ch entries, each with a per-entry enable.
- Performs a sequential lowest-index search per packet and returns the client select index (udp_sel) with hit/miss status.
- Sits between the packet scanner (supplies the destination port) and the packet-buffer writer/status path, all in the Rx clock domain.

---
 rtl/udp_port_seq_match.sv | 159 +++++++++++++++
 tb/tb_udp_port_seq_match.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_port_seq_match.sv
// udp_port_seq_match
// Run-time configurable UDP destination-port matcher for the Rx path.
// Each packet's port is looked up by a sequential, lowest-index-first scan
// of an n_ch-entry table. The result (hit, udp_sel) is presented with a
// one-cycle done strobe.
// Optional feature macro: UDP_PORT_SEQ_STATS_EN builds saturating per-entry
// hit counters and a miss counter, readable through stat_sel/stat_cnt.
module udp_port_seq_match #(
  parameter int n_ch       = 8,
  parameter int sel_w      = 3,
  parameter int init_port0 = 7,
  parameter int cnt_w      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [sel_w-1:0] cfg_addr,
  input  logic [15:0]      cfg_port,
  input  logic             cfg_en,
  input  logic             start,
  input  logic [15:0]      dst_port,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [sel_w-1:0] udp_sel,
  input  logic [sel_w:0]   stat_sel,
  input  logic             stat_clr,
  output logic [cnt_w-1:0] stat_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [sel_w-1:0] LAST_IDX = sel_w'(n_ch - 1);

  logic [1:0]       state;
  logic [sel_w-1:0] idx;
  logic [15:0]      key;
  logic [15:0]      port_tab [n_ch];
  logic [n_ch-1:0]  en_tab;
  logic             match;

  // Port table: entry 0 comes up as the echo service, others disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < n_ch; i++) begin
        port_tab[i] <= '0;
      end
      port_tab[0] <= 16'(init_port0);
      en_tab      <= '0;
      en_tab[0]   <= 1'b1;
    end else if (cfg_we && (int'(cfg_addr) < n_ch)) begin
      port_tab[cfg_addr] <= cfg_port;
      en_tab[cfg_addr]   <= cfg_en;
    end
  end

  // Compare the current entry; a zero key is never a valid port
  always_comb begin
    match = en_tab[idx] && (port_tab[idx] == key) && (key != 16'd0);
  end

  // Search key capture; only meaningful while a search is running
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      key <= dst_port;
    end
  end

  // Search FSM: scan upward from entry 0, stop on first match or last entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      hit     <= 1'b0;
      udp_sel <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (match) begin
            hit     <= 1'b1;
            udp_sel <= idx;
            state   <= S_REPORT;
          end else if (idx == LAST_IDX) begin
            hit     <= 1'b0;
            udp_sel <= '0;
            state   <= S_REPORT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_REPORT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status decode straight from the state register
  always_comb begin
    busy = (state == S_SEARCH);
    done = (state == S_REPORT);
  end

`ifdef UDP_PORT_SEQ_STATS_EN
  logic [cnt_w-1:0] cnt [n_ch+1];

  // Saturating counters: entries 0..n_ch-1 count hits, entry n_ch counts misses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= n_ch; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= n_ch; i++) begin
        if (stat_clr) begin
          cnt[i] <= '0;
        end else if (done && (cnt[i] != {cnt_w{1'b1}})) begin
          if (i == n_ch) begin
            if (!hit) cnt[i] <= cnt[i] + 1'b1;
          end else if (hit && (int'(udp_sel) == i)) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Registered readback; out-of-range selects read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else if (int'(stat_sel) <= n_ch) begin
      stat_cnt <= cnt[stat_sel];
    end else begin
      stat_cnt <= '0;
    end
  end
`else
  logic unused_stat;

  // Statistics not built: readback is tied off
  always_comb begin
    stat_cnt    = '0;
    unused_stat = ^{stat_sel, stat_clr};
  end
`endif

endmodule

// File: tb/tb_udp_port_seq_match.sv
// Directed testbench for udp_port_seq_match (n_ch=8).
// Statistics checks are built only when UDP_PORT_SEQ_STATS_EN is defined.
module tb_udp_port_seq_match;

  localparam int NCH = 8;
  localparam int SW  = 3;
`ifdef UDP_PORT_SEQ_STATS_EN
  localparam int CW  = 4;
`else
  localparam int CW  = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [SW-1:0] cfg_addr;
  logic [15:0]   cfg_port;
  logic          cfg_en;
  logic          start;
  logic [15:0]   dst_port;
  logic          busy;
  logic          done;
  logic          hit;
  logic [SW-1:0] udp_sel;
  logic [SW:0]   stat_sel;
  logic          stat_clr;
  logic [CW-1:0] stat_cnt;

  int errors = 0;
  int checks = 0;

  udp_port_seq_match #(
    .n_ch(NCH), .sel_w(SW), .init_port0(7), .cnt_w(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_port(cfg_port), .cfg_en(cfg_en),
    .start(start), .dst_port(dst_port),
    .busy(busy), .done(done), .hit(hit), .udp_sel(udp_sel),
    .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int addr, input logic en, input logic [15:0] port);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = SW'(addr);
    cfg_port = port;
    cfg_en   = en;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Issue one start, wait for done (bounded), check latency and result.
  // With dbl set, a second start is pulsed mid-search and must be dropped.
  task automatic run(input string tag, input logic [15:0] port, input logic exp_hit,
                     input int exp_sel, input int exp_lat, input bit dbl);
    int cyc;
    int bcnt;
    int nd;
    @(negedge clk);
    start    = 1'b1;
    dst_port = port;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    bcnt  = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      if (dbl && cyc == 2) begin
        start    = 1'b1;
        dst_port = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    chk({tag, "_sel"}, 32'(udp_sel), 32'(exp_sel));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat - 1));
    if (dbl) begin
      nd = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) nd++;
      end
      chk({tag, "_no_extra_done"}, 32'(nd), 32'd0);
      chk({tag, "_hit_hold"}, 32'(hit), 32'(exp_hit));
    end
  endtask

  task automatic read_stat(input string tag, input int sel, input int exp);
    @(negedge clk);
    stat_sel = (SW+1)'(sel);
    @(negedge clk);
    @(negedge clk);
    chk(tag, 32'(stat_cnt), 32'(exp));
  endtask

  initial begin
    int nd;
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_port = '0;
    cfg_en   = 1'b0;
    start    = 1'b0;
    dst_port = '0;
    stat_sel = '0;
    stat_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_sel", 32'(udp_sel), 32'd0);
    chk("rst_stat", 32'(stat_cnt), 32'd0);
    rst_n = 1'b1;

    run("echo", 16'd7, 1'b1, 0, 2, 1'b0);

    cfg_write(5, 1'b1, 16'd803);
    run("e5", 16'd803, 1'b1, 5, 7, 1'b0);
    run("e5_b2b", 16'd803, 1'b1, 5, 7, 1'b0);

    cfg_write(2, 1'b1, 16'd801);
    cfg_write(6, 1'b1, 16'd801);
    run("dup", 16'd801, 1'b1, 2, 4, 1'b0);
    cfg_write(2, 1'b0, 16'd801);
    run("dup_dis", 16'd801, 1'b1, 6, 8, 1'b0);

    cfg_write(3, 1'b1, 16'd0);
    run("key0", 16'd0, 1'b0, 0, 9, 1'b0);
    run("unmapped", 16'd9999, 1'b0, 0, 9, 1'b1);

    // Reset two cycles into a search
    @(negedge clk);
    start    = 1'b1;
    dst_port = 16'd803;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    run("after_rst", 16'd803, 1'b0, 0, 9, 1'b0);

`ifdef UDP_PORT_SEQ_STATS_EN
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    read_stat("stat_clr0", NCH, 0);
    for (int i = 0; i < 20; i++) begin
      run("sh", 16'd7, 1'b1, 0, 2, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      run("sm", 16'd9999, 1'b0, 0, 9, 1'b0);
    end
    read_stat("stat_hit_sat", 0, 15);
    read_stat("stat_miss", NCH, 3);
    read_stat("stat_unused", 5, 0);
    read_stat("stat_oob", NCH + 1, 0);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    read_stat("stat_clr_hit", 0, 0);
    read_stat("stat_clr_miss", NCH, 0);
`else
    read_stat("stat_off", 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
